ssd1306_spi_streamer: RTL and testbench
=======================================

# ssd1306_spi_streamer

Parametrised second-generation SPI driver for SSD1306-class OLED panels. It sequences power-up and reset, sends a fixed initialisation list, then streams whole frames out of an external byte-wide framebuffer RAM on request. The SPI clock rate, panel geometry and startup delay are set by parameters. It sits between the pixel-generation logic, which owns the framebuffer RAM, and the OLED pins.

## Interface
- DISPLAY_WIDTH, 128: columns per page.
- DISPLAY_PAGES, 8: 8-pixel pages (height/8).
- CLK_DIV, 2: clk cycles per SCLK half-period, at least 1.
- STARTUP_DELAY, 1000000: clk cycles for each power-up phase, at least 1.
- CONTRAST, 8'h7F: contrast byte sent during init.
- ADDR_W, 10: framebuffer address width, at least clog2(DISPLAY_WIDTH*DISPLAY_PAGES).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- refresh  in  1  single-cycle frame-refresh request
- busy  out  1  high whenever the FSM is not in IDLE
- frame_done  out  1  one-cycle pulse after the last data byte of a frame
- fb_addr  out  ADDR_W  framebuffer byte address, page-major: page*DISPLAY_WIDTH + column
- fb_rd  out  1  one-cycle read strobe
- fb_data  in  8  read data, valid exactly 1 clk after fb_rd
- sclk, sdin, res, cmd, cs  out  1 each  OLED pins; cmd: 0 = command, 1 = data; cs active low

## Operation
- Reset values: sclk=0, sdin=0, res=1, cmd=0, cs=1, busy=1, frame_done=0, fb_rd=0, fb_addr=0. The FSM enters PRE_RESET and the pending flag clears.
- States:
  - PRE_RESET: res=1 for STARTUP_DELAY cycles.
  - RESETTING: res=0 for STARTUP_DELAY cycles.
  - POST_RESET: res=1 for STARTUP_DELAY cycles.
  - INIT: 10 command bytes in order: AE, 20, 00, 81, CONTRAST, A6, A4, 8D, 14, AF.
  - IDLE.
  - WINDOW: 6 command bytes in order: 21, 00, DISPLAY_WIDTH-1, 22, 00, DISPLAY_PAGES-1.
  - STREAM: DISPLAY_WIDTH*DISPLAY_PAGES data bytes, addresses 0 upward.
  - DONE: 1 cycle, frame_done=1, then IDLE.
- Byte engine (SPI mode 0, MSB first):
  - A 1-cycle LOAD precedes each byte. During LOAD, sclk=0, cmd is set for that byte, and sdin takes bit 7.
  - Each bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - sdin changes only in the first low cycle of each bit.
- cs goes low at the first LOAD of INIT, WINDOW or STREAM. It stays low across consecutive bytes and returns high at the first cycle of IDLE.
- refresh sets the pending flag in any state. IDLE with the flag set clears the flag and enters WINDOW the next cycle. At most one request is held; extra requests while pending are absorbed.
- Framebuffer prefetch:
  - STREAM byte k is taken from a prefetch register.
  - fb_rd for address k+1 pulses on the LOAD cycle of byte k, and fb_data is captured on the next clk.
  - Byte 0 is fetched during the LOAD of the last WINDOW byte.
  - No fb_rd is issued past the last address.
- fb_addr holds its last value between reads. The address counter uses ADDR_W bits and reaches DISPLAY_WIDTH*DISPLAY_PAGES-1 without wrap.

## Timing
- Byte period: 1 + 16*CLK_DIV clk cycles.
- Frame, from the refresh-accept cycle to frame_done: 1 + (6 + DISPLAY_WIDTH*DISPLAY_PAGES)*(1 + 16*CLK_DIV) cycles.
- Startup: 3*STARTUP_DELAY cycles, then 10 init bytes, then IDLE.
- rst_n asserted mid-byte:
  - All outputs return to reset values immediately; the truncated byte is discarded.
  - After rst_n deasserts, the full startup and init sequence reruns.

## Configuration
- SSD1306_AUTO_REFRESH_EN:
  - Defined: DONE returns directly to WINDOW with no IDLE cycle, so frames stream continuously. cs stays low between frames; busy stays high after init. refresh is ignored.
  - Undefined: frames are sent only on refresh, as described above.

## Test plan
All scenarios use STARTUP_DELAY=4, CLK_DIV=1, DISPLAY_WIDTH=4, DISPLAY_PAGES=2 unless stated.
- Reset and startup: release rst_n -> res reads 1, 0, 1 in phases of 4 cycles each. Then 10 bytes (AE, 20, 00, 81, 7F, A6, A4, 8D, 14, AF) with cmd=0, decoded on sclk rising edges. busy falls 3*4 + 10*17 cycles after release.
- Single frame: fb contents 0x01..0x08, pulse refresh in IDLE -> bytes 21, 00, 03, 22, 00, 01 with cmd=0, then 01..08 with cmd=1. frame_done pulses at 1 + 14*17 cycles after the refresh-accept cycle. cs rises on the next cycle.
- Pending request: pulse refresh twice during init -> exactly one frame after init, then IDLE. Pulse refresh during that frame -> exactly one more frame.
- fb latency: randomised fb_data that is valid only 1 cycle after each fb_rd -> all 8 bytes correct. fb_addr sequence reads 0..7, with no fb_rd past 7.
- CLK_DIV=3: sclk high and low phases are each 3 cycles; byte period 49 cycles; sdin stable while sclk=1.
- Mid-frame reset: assert rst_n low during data byte 4 -> cs=1, sclk=0, res=1 on the same edge. After release, the startup sequence restarts, and a refresh then produces a full frame.

Source files
------------

// File: rtl/ssd1306_spi_streamer.sv
// SSD1306 OLED driver: power-up/reset sequencing, fixed init list, then framebuffer frames over SPI mode 0.
// Optional build macro SSD1306_AUTO_REFRESH_EN streams frames back-to-back and ignores refresh.
module ssd1306_spi_streamer #(
  parameter int         DISPLAY_WIDTH = 128,
  parameter int         DISPLAY_PAGES = 8,
  parameter int         CLK_DIV       = 2,
  parameter int         STARTUP_DELAY = 1000000,
  parameter logic [7:0] CONTRAST      = 8'h7F,
  parameter int         ADDR_W        = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              refresh,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [7:0]        fb_data,
  output logic              sclk,
  output logic              sdin,
  output logic              res,
  output logic              cmd,
  output logic              cs
);

  localparam int NBYTES = DISPLAY_WIDTH * DISPLAY_PAGES;
  localparam int IDX_W  = (ADDR_W > 4) ? ADDR_W : 4;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef SSD1306_AUTO_REFRESH_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    PRE_RESET, RESETTING, POST_RESET, INIT, IDLE, WINDOW, STREAM, DONE
  } state_t;

  state_t            state, state_nx;
  logic [31:0]       dly_cnt;
  logic              dly_end, pend, in_load, half, bit_end, byte_end, byte_st, rd_d;
  logic [2:0]        bit_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        byte_val, shreg, pf;
  logic [ADDR_W-1:0] addr_hold;

  assign byte_st  = (state == INIT) || (state == WINDOW) || (state == STREAM);
  assign bit_end  = byte_st && !in_load && half && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign byte_end = bit_end && (bit_cnt == 3'd7);
  assign dly_end  = (dly_cnt == 32'(STARTUP_DELAY - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PRE_RESET;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      PRE_RESET:  if (dly_end) state_nx = RESETTING;
      RESETTING:  if (dly_end) state_nx = POST_RESET;
      POST_RESET: if (dly_end) state_nx = INIT;
      INIT:       if (byte_end && idx == IDX_W'(9)) state_nx = AUTO_EN ? WINDOW : IDLE;
      IDLE:       if (pend) state_nx = WINDOW;
      WINDOW:     if (byte_end && idx == IDX_W'(5)) state_nx = STREAM;
      STREAM:     if (byte_end && idx == IDX_W'(NBYTES - 1)) state_nx = DONE;
      DONE:       state_nx = AUTO_EN ? WINDOW : IDLE;
      default:    state_nx = PRE_RESET;
    endcase
  end

  // Pin decode; fb_addr follows the read address only while fb_rd is high, else holds.
  always_comb begin
    res        = (state != RESETTING);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    cmd        = (state == STREAM);
    cs         = !(byte_st || state == DONE);
    sclk       = byte_st && !in_load && half;
    fb_rd      = in_load && ((state == WINDOW && idx == IDX_W'(5)) ||
                             (state == STREAM && idx != IDX_W'(NBYTES - 1)));
    fb_addr    = addr_hold;
    if (fb_rd) fb_addr = (state == STREAM) ? ADDR_W'(idx + IDX_W'(1)) : '0;
  end

  always_comb begin
    byte_val = pf;
    if (state == INIT) begin
      case (idx[3:0])
        4'd0: byte_val = 8'hAE;
        4'd1: byte_val = 8'h20;
        4'd2: byte_val = 8'h00;
        4'd3: byte_val = 8'h81;
        4'd4: byte_val = CONTRAST;
        4'd5: byte_val = 8'hA6;
        4'd6: byte_val = 8'hA4;
        4'd7: byte_val = 8'h8D;
        4'd8: byte_val = 8'h14;
        default: byte_val = 8'hAF;
      endcase
    end else if (state == WINDOW) begin
      case (idx[3:0])
        4'd0: byte_val = 8'h21;
        4'd1: byte_val = 8'h00;
        4'd2: byte_val = 8'(DISPLAY_WIDTH - 1);
        4'd3: byte_val = 8'h22;
        4'd4: byte_val = 8'h00;
        default: byte_val = 8'(DISPLAY_PAGES - 1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      if (state_nx != state) dly_cnt <= '0;
      else if (state == PRE_RESET || state == RESETTING || state == POST_RESET)
        dly_cnt <= dly_cnt + 32'd1;
`ifdef SSD1306_AUTO_REFRESH_EN
      pend <= 1'b0;
`else
      if (refresh)             pend <= 1'b1;
      else if (state == IDLE)  pend <= 1'b0;
`endif
    end
  end

  // Byte engine: LOAD cycle, then 8 bits of CLK_DIV low + CLK_DIV high cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_load <= 1'b1;
      half    <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
      idx     <= '0;
      sdin    <= 1'b0;
    end else if (state_nx != state || !byte_st) begin
      in_load <= 1'b1;
      half    <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
      idx     <= '0;
    end else if (in_load) begin
      in_load <= 1'b0;
      sdin    <= byte_val[7];
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      half    <= !half;
      if (half) begin
        if (bit_cnt == 3'd7) begin
          in_load <= 1'b1;
          bit_cnt <= '0;
          idx     <= idx + IDX_W'(1);
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          sdin    <= shreg[7];
        end
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d      <= 1'b0;
      addr_hold <= '0;
    end else begin
      rd_d      <= fb_rd;
      addr_hold <= fb_addr;
    end
  end

  // Shift and prefetch data: fb_data is valid the cycle after fb_rd.
  always_ff @(posedge clk) begin
    if (in_load)      shreg <= {byte_val[6:0], 1'b0};
    else if (bit_end) shreg <= {shreg[6:0], 1'b0};
    if (rd_d) pf <= fb_data;
  end

endmodule

// File: tb/tb_ssd1306_spi_streamer.sv
// Directed bench for ssd1306_spi_streamer: startup, frames, pending requests, fb latency, CLK_DIV=3, mid-frame reset.
module tb_ssd1306_spi_streamer;
  logic       clk = 1'b0, rst_n = 1'b0, refresh = 1'b0;
  logic       busy, frame_done, fb_rd, sclk, sdin, res, cmd, cs;
  logic [9:0] fb_addr;
  logic [7:0] fb_data = 8'h00;
  logic       busy3, frame_done3, fb_rd3, sclk3, sdin3, res3, cmd3, cs3;
  logic [9:0] fb_addr3;
  logic [7:0] fb_data3 = 8'hA5;

  int total = 0, bad = 0, kk = 0, nfd = 0, mnb = 0, viol3 = 0;
  logic [7:0] mem [8];
  logic [8:0] bq [$];
  logic [9:0] rq [$];
  logic [7:0] msh = 8'h00;
  logic       p_sclk3 = 1'b0, p_sdin3 = 1'b0;

  always #5 clk = ~clk;

  ssd1306_spi_streamer #(.DISPLAY_WIDTH(4), .DISPLAY_PAGES(2), .CLK_DIV(1), .STARTUP_DELAY(4)) dut (
    .clk(clk), .rst_n(rst_n), .refresh(refresh), .busy(busy), .frame_done(frame_done),
    .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data), .sclk(sclk), .sdin(sdin),
    .res(res), .cmd(cmd), .cs(cs));

  ssd1306_spi_streamer #(.DISPLAY_WIDTH(4), .DISPLAY_PAGES(2), .CLK_DIV(3), .STARTUP_DELAY(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .refresh(refresh), .busy(busy3), .frame_done(frame_done3),
    .fb_addr(fb_addr3), .fb_rd(fb_rd3), .fb_data(fb_data3), .sclk(sclk3), .sdin(sdin3),
    .res(res3), .cmd(cmd3), .cs(cs3));

  // SPI byte decoder on sclk rising edges; a reset drops any partial byte.
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) mnb = 0;
    else begin
      msh = {msh[6:0], sdin};
      mnb++;
      if (mnb == 8) begin
        bq.push_back({cmd, msh});
        mnb = 0;
      end
    end
  end

  // Framebuffer model: data valid only the cycle after fb_rd, garbage otherwise.
  always @(posedge clk) begin
    if (fb_rd) rq.push_back(fb_addr);
    if (frame_done) nfd++;
    fb_data <= fb_rd ? mem[fb_addr[2:0]] : 8'($urandom);
  end

  always @(negedge clk) begin
    if (sclk3 && p_sclk3 && sdin3 !== p_sdin3) viol3++;
    p_sclk3 = sclk3;
    p_sdin3 = sdin3;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int t);
    while (kk < t) begin
      @(negedge clk);
      kk++;
    end
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (frame_done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", 32'(frame_done), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_init(input int b);
    logic [7:0] ini [10];
    ini = '{8'hAE, 8'h20, 8'h00, 8'h81, 8'h7F, 8'hA6, 8'hA4, 8'h8D, 8'h14, 8'hAF};
    for (int i = 0; i < 10; i++) chk($sformatf("init_byte%0d", i), 32'(bq[b+i]), 32'({1'b0, ini[i]}));
  endtask

  task automatic check_frame(input int b, input int r);
    logic [7:0] win [6];
    win = '{8'h21, 8'h00, 8'h03, 8'h22, 8'h00, 8'h01};
    for (int i = 0; i < 6; i++) chk($sformatf("win_byte%0d", i), 32'(bq[b+i]), 32'({1'b0, win[i]}));
    for (int i = 0; i < 8; i++) chk($sformatf("data_byte%0d", i), 32'(bq[b+6+i]), 32'({1'b1, mem[i]}));
    for (int i = 0; i < 8; i++) chk($sformatf("fb_addr_rd%0d", i), 32'(rq[r+i]), i);
  endtask

  initial begin
    int b0, r0, n0;
    repeat (3) @(negedge clk);
    chk("reset_pins", 32'({sclk, sdin, res, cmd, cs, busy, frame_done, fb_rd}), 32'b0010_1100);
    chk("reset_fb_addr", 32'(fb_addr), 32'd0);

    // Startup: release, power phases, init list; dut3 timing at CLK_DIV=3.
    rst_n = 1'b1;
    kk = 0;
    adv(3);   chk("res_pre", 32'(res), 32'd1);
    adv(4);   chk("res_low_first", 32'(res), 32'd0);
    adv(7);   chk("res_low_last", 32'(res), 32'd0);
    adv(8);   chk("res_post", 32'(res), 32'd1);
    adv(11);  chk("cs_before_init", 32'(cs), 32'd1);
    adv(12);  chk("init_load_pins", 32'({cs, sclk, cmd}), 32'b000);
    adv(15);  chk("div3_low_end", 32'(sclk3), 32'd0);
    adv(16);  chk("div3_high_start", 32'(sclk3), 32'd1);
    adv(18);  chk("div3_high_end", 32'(sclk3), 32'd1);
    adv(19);  chk("div3_next_low", 32'(sclk3), 32'd0);
    adv(60);  chk("div3_byte0_last_high", 32'(sclk3), 32'd1);
    adv(61);  chk("div3_byte1_load", 32'(sclk3), 32'd0);
    adv(64);  chk("div3_byte1_low", 32'(sclk3), 32'd0);
    adv(65);  chk("div3_byte1_high", 32'(sclk3), 32'd1);
    adv(181); chk("busy_end_init", 32'(busy), 32'd1);
    adv(182); chk("idle_busy_cs", 32'({busy, cs}), 32'b01);
    chk("init_count", bq.size(), 32'd10);
    check_init(0);
    adv(501); chk("busy3_end_init", 32'(busy3), 32'd1);
    adv(502); chk("busy3_idle", 32'(busy3), 32'd0);

    // Single frame with fb 01..08 and exact frame_done timing.
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    b0 = bq.size();
    r0 = rq.size();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    chk("accept_in_idle", 32'(busy), 32'd0);
    repeat (238) @(negedge clk);
    chk("frame_done_early", 32'(frame_done), 32'd0);
    @(negedge clk);
    chk("frame_done_pulse", 32'({frame_done, cs}), 32'b10);
    @(negedge clk);
    chk("after_done", 32'({frame_done, cs, busy}), 32'b010);
    chk("frame1_count", bq.size() - b0, 32'd14);
    chk("frame1_reads", rq.size() - r0, 32'd8);
    check_frame(b0, r0);

    // Random framebuffer contents.
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    b0 = bq.size();
    r0 = rq.size();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_done(400);
    chk("frame2_count", bq.size() - b0, 32'd14);
    chk("frame2_reads", rq.size() - r0, 32'd8);
    check_frame(b0, r0);

    // Reset during data byte 4, while sclk is high.
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    repeat (173) @(negedge clk);
    chk("mid_byte4_sclk_cmd", 32'({sclk, cmd}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("async_reset_pins", 32'({cs, sclk, res, busy}), 32'b1011);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    kk = 0;
    b0 = bq.size();
    r0 = rq.size();

    // Two requests during init collapse into one frame; one more during that frame.
    adv(20);  refresh = 1'b1;
    adv(21);  refresh = 1'b0;
    adv(40);  refresh = 1'b1;
    adv(41);  refresh = 1'b0;
    adv(181); chk("rerun_init_busy", 32'(busy), 32'd1);
    adv(182); chk("rerun_accept", 32'(busy), 32'd0);
    n0 = nfd;
    adv(282); refresh = 1'b1;
    adv(283); refresh = 1'b0;
    wait_done(400);
    wait_done(400);
    repeat (300) @(negedge clk);
    chk("pending_frames", nfd - n0, 32'd2);
    chk("final_idle", 32'({busy, cs}), 32'b01);
    chk("rerun_byte_count", bq.size() - b0, 32'd38);
    chk("rerun_read_count", rq.size() - r0, 32'd16);
    check_init(b0);
    check_frame(b0 + 10, r0);
    check_frame(b0 + 24, r0 + 8);
    chk("div3_sdin_stable", viol3, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
